seq_stepper: RTL and testbench

SEQ_STEPPER -- requirements
Module: seq_stepper

---
 rtl/seq_stepper.sv | 137 +++++++++++++
 tb/tb_seq_stepper.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_stepper.sv
// Note sequencer: walks a synchronous note ROM from address 0 and presents each
// note for (freq_num+1) base ticks. It stops at the end marker or at the last ROM address.
module seq_stepper #(
  parameter int         TICK_BASE = 50000,
  parameter logic [7:0] END_CODE  = 8'hFF
) (
  input  logic       CLOCK_50,
  input  logic       KEY0,
  input  logic       start,
  input  logic       stop,
  input  logic [6:0] seq_sel,
  input  logic [2:0] freq_sel,
  input  logic [7:0] rom_data,
  output logic [6:0] rom_addr,
  output logic [6:0] seq_num,
  output logic [2:0] freq_num,
  output logic [7:0] note_code,
  output logic       note_valid,
  output logic       busy,
  output logic       done
);

  localparam int            PW         = (TICK_BASE > 1) ? $clog2(TICK_BASE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_BASE - 1);
  localparam logic [6:0]    ADDR_LAST  = 7'd127;
  localparam logic [6:0]    SEQ_MAX    = 7'd99;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    READ,
    PLAY,
    DONE
  } state_t;

  state_t        state, state_nx;
  logic [PW-1:0] presc, presc_nx;
  logic [2:0]    step_cnt, step_nx;
  logic [6:0]    addr_nx, seq_nx;
  logic [2:0]    freq_nx;
  logic [7:0]    note_nx;
  logic          valid_nx, busy_nx, done_nx;
  logic          tick_wrap, step_end;

  // A step ends on the base tick that completes freq_num+1 ticks.
  assign tick_wrap = (presc == PRESC_LAST);
  assign step_end  = tick_wrap && (step_cnt == freq_num);

  always_comb begin
    state_nx = state;
    presc_nx = presc;
    step_nx  = step_cnt;
    addr_nx  = rom_addr;
    seq_nx   = seq_num;
    freq_nx  = freq_num;
    note_nx  = note_code;
    valid_nx = 1'b0;

    if (stop && (state != IDLE)) begin
      state_nx = IDLE;
      note_nx  = 8'h00;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start && !stop) begin
            state_nx = FETCH;
            addr_nx  = 7'd0;
            freq_nx  = freq_sel;
            seq_nx   = (seq_sel > SEQ_MAX) ? SEQ_MAX : seq_sel;
            presc_nx = '0;
            step_nx  = 3'd0;
          end
        end
        FETCH: begin
          state_nx = READ;
        end
        READ: begin
          if (rom_data == END_CODE) begin
            state_nx = DONE;
          end else begin
            note_nx  = rom_data;
            valid_nx = 1'b1;
            state_nx = PLAY;
          end
        end
        PLAY: begin
          presc_nx = tick_wrap ? '0 : presc + PW'(1);
          if (tick_wrap) begin
            step_nx = step_end ? 3'd0 : step_cnt + 3'd1;
          end
          // The last ROM address finishes the sequence instead of wrapping to 0.
          if (step_end) begin
            if (rom_addr != ADDR_LAST) begin
              addr_nx  = rom_addr + 7'd1;
              state_nx = FETCH;
            end else begin
              state_nx = DONE;
            end
          end
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end

    busy_nx = (state_nx == FETCH) || (state_nx == READ) || (state_nx == PLAY);
    done_nx = (state_nx == DONE);
  end

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      state      <= IDLE;
      presc      <= '0;
      step_cnt   <= 3'd0;
      rom_addr   <= 7'd0;
      seq_num    <= 7'd0;
      freq_num   <= 3'd0;
      note_code  <= 8'h00;
      note_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nx;
      presc      <= presc_nx;
      step_cnt   <= step_nx;
      rom_addr   <= addr_nx;
      seq_num    <= seq_nx;
      freq_num   <= freq_nx;
      note_code  <= note_nx;
      note_valid <= valid_nx;
      busy       <= busy_nx;
      done       <= done_nx;
    end
  end

endmodule

// File: tb/tb_seq_stepper.sv
// Bench for seq_stepper with TICK_BASE=4. It drives a table of per-cycle vectors,
// then runs hand-written sequences for clamp/rate, end of ROM, abort and async reset.
module tb_seq_stepper;

  logic       CLOCK_50 = 1'b0;
  logic       KEY0;
  logic       start, stop;
  logic [6:0] seq_sel;
  logic [2:0] freq_sel;
  logic [7:0] rom_data;
  logic [6:0] rom_addr, seq_num;
  logic [2:0] freq_num;
  logic [7:0] note_code;
  logic       note_valid, busy, done;

  logic [7:0] romMem [128];
  int compared   = 0;
  int mismatched = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  // The ROM is synchronous and has one cycle of latency, like the board's block RAM.
  always @(posedge CLOCK_50) rom_data <= romMem[rom_addr];

  seq_stepper #(.TICK_BASE(4), .END_CODE(8'hFF)) dut (
    .CLOCK_50  (CLOCK_50),
    .KEY0      (KEY0),
    .start     (start),
    .stop      (stop),
    .seq_sel   (seq_sel),
    .freq_sel  (freq_sel),
    .rom_data  (rom_data),
    .rom_addr  (rom_addr),
    .seq_num   (seq_num),
    .freq_num  (freq_num),
    .note_code (note_code),
    .note_valid(note_valid),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic        start;
    logic        stop;
    logic [6:0]  seqSel;
    logic [2:0]  freqSel;
    logic [27:0] expOut;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [27:0] packOut(input logic [6:0] a, input logic [6:0] s,
                                          input logic [2:0] f, input logic [7:0] n,
                                          input logic v, input logic b, input logic d);
    return {a, s, f, n, v, b, d};
  endfunction

  function automatic logic [27:0] actualOut();
    return {rom_addr, seq_num, freq_num, note_code, note_valid, busy, done};
  endfunction

  function automatic void addVec(input logic st, input logic sp, input logic [6:0] ss,
                                 input logic [2:0] fs, input logic [27:0] e);
    vec_t v;
    v.start   = st;
    v.stop    = sp;
    v.seqSel  = ss;
    v.freqSel = fs;
    v.expOut  = e;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs are driven just after a falling edge and outputs are read at the next falling edge.
  task automatic applyStimulus(input logic st, input logic sp, input logic [6:0] ss,
                               input logic [2:0] fs);
    start    = st;
    stop     = sp;
    seq_sel  = ss;
    freq_sel = fs;
    @(negedge CLOCK_50);
  endtask

  task automatic fillRom(input logic [7:0] n0, input logic [7:0] n1, input logic [7:0] n2);
    for (int i = 0; i < 128; i++) romMem[i] = 8'hFF;
    romMem[0] = n0;
    romMem[1] = n1;
    romMem[2] = n2;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, hold, pulses, badNotes, badPairs, wrapped, busyHigh;
    logic prevNv, leftZero;

    start = 1'b0; stop = 1'b0; seq_sel = 7'd0; freq_sel = 3'd0;
    fillRom(8'h10, 8'h20, 8'hFF);
    KEY0 = 1'b1;
    #2 KEY0 = 1'b0;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    checkOutput("reset_state", 32'(actualOut()), 32'd0);
    KEY0 = 1'b1;
    applyStimulus(1'b0, 1'b0, 7'd0, 3'd0);
    checkOutput("idle_after_release", 32'(actualOut()), 32'd0);

    // Basic run with freq 1: each note plays for 8 cycles, and pulses are 10 cycles apart.
    // A start and changed selectors in mid-sequence must be ignored.
    addVec(1'b1, 1'b0, 7'd5, 3'd1, packOut(7'd0, 7'd5, 3'd1, 8'h00, 1'b0, 1'b1, 1'b0));
    addVec(1'b0, 1'b0, 7'd5, 3'd1, packOut(7'd0, 7'd5, 3'd1, 8'h00, 1'b0, 1'b1, 1'b0));
    addVec(1'b0, 1'b0, 7'd5, 3'd1, packOut(7'd0, 7'd5, 3'd1, 8'h10, 1'b1, 1'b1, 1'b0));
    for (int i = 0; i < 7; i++)
      addVec(i == 2, 1'b0, 7'd40, 3'd3, packOut(7'd0, 7'd5, 3'd1, 8'h10, 1'b0, 1'b1, 1'b0));
    addVec(1'b1, 1'b0, 7'd40, 3'd3, packOut(7'd1, 7'd5, 3'd1, 8'h10, 1'b0, 1'b1, 1'b0));
    addVec(1'b0, 1'b0, 7'd40, 3'd3, packOut(7'd1, 7'd5, 3'd1, 8'h10, 1'b0, 1'b1, 1'b0));
    addVec(1'b0, 1'b0, 7'd40, 3'd3, packOut(7'd1, 7'd5, 3'd1, 8'h20, 1'b1, 1'b1, 1'b0));
    for (int i = 0; i < 7; i++)
      addVec(1'b0, 1'b0, 7'd40, 3'd3, packOut(7'd1, 7'd5, 3'd1, 8'h20, 1'b0, 1'b1, 1'b0));
    addVec(1'b0, 1'b0, 7'd40, 3'd3, packOut(7'd2, 7'd5, 3'd1, 8'h20, 1'b0, 1'b1, 1'b0));
    addVec(1'b0, 1'b0, 7'd40, 3'd3, packOut(7'd2, 7'd5, 3'd1, 8'h20, 1'b0, 1'b1, 1'b0));
    addVec(1'b0, 1'b0, 7'd40, 3'd3, packOut(7'd2, 7'd5, 3'd1, 8'h20, 1'b0, 1'b0, 1'b1));
    addVec(1'b0, 1'b0, 7'd40, 3'd3, packOut(7'd2, 7'd5, 3'd1, 8'h20, 1'b0, 1'b0, 1'b1));
    addVec(1'b0, 1'b1, 7'd40, 3'd3, packOut(7'd2, 7'd5, 3'd1, 8'h00, 1'b0, 1'b0, 1'b0));
    addVec(1'b1, 1'b1, 7'd40, 3'd3, packOut(7'd2, 7'd5, 3'd1, 8'h00, 1'b0, 1'b0, 1'b0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].start, vecs[i].stop, vecs[i].seqSel, vecs[i].freqSel);
      checkOutput($sformatf("vec%0d", i), 32'(actualOut()), 32'(vecs[i].expOut));
    end

    // Clamp and slowest rate: seq 120 latches as 99, and note 33 plays for 32 cycles.
    fillRom(8'h33, 8'hFF, 8'hFF);
    applyStimulus(1'b1, 1'b0, 7'd120, 3'd7);
    checkOutput("clamp_seq", 32'(seq_num), 32'd99);
    checkOutput("clamp_freq", 32'(freq_num), 32'd7);
    lat = 1;
    while (!note_valid && lat < 10) begin
      applyStimulus(1'b0, 1'b0, 7'd120, 3'd7);
      lat++;
    end
    checkOutput("clamp_latency", 32'(lat), 32'd3);
    checkOutput("clamp_note", 32'(note_code), 32'h33);
    hold = 0;
    while (rom_addr == 7'd0 && hold < 100) begin
      applyStimulus(1'b0, 1'b0, 7'd0, 3'd0);
      hold++;
    end
    checkOutput("clamp_hold", 32'(hold), 32'd32);
    applyStimulus(1'b0, 1'b0, 7'd0, 3'd0);
    applyStimulus(1'b0, 1'b0, 7'd0, 3'd0);
    checkOutput("clamp_done", 32'({done, busy, rom_addr, note_code}), 32'({1'b1, 1'b0, 7'd1, 8'h33}));
    applyStimulus(1'b0, 1'b1, 7'd0, 3'd0);

    // End of ROM: 128 notes and no end marker. The sequence must stop at address 127.
    for (int i = 0; i < 128; i++) romMem[i] = 8'(i);
    applyStimulus(1'b1, 1'b0, 7'd3, 3'd0);
    pulses = 0; badNotes = 0; badPairs = 0; wrapped = 0;
    prevNv = 1'b0; leftZero = 1'b0;
    for (int c = 0; c < 1500 && !done; c++) begin
      applyStimulus(1'b0, 1'b0, 7'd3, 3'd0);
      if (note_valid) begin
        if (note_code != 8'(pulses)) badNotes++;
        pulses++;
      end
      if (prevNv && note_valid) badPairs++;
      prevNv = note_valid;
      if (rom_addr != 7'd0) leftZero = 1'b1;
      else if (leftZero) wrapped++;
    end
    checkOutput("eor_pulses", 32'(pulses), 32'd128);
    checkOutput("eor_notes", 32'(badNotes), 32'd0);
    checkOutput("eor_back_to_back", 32'(badPairs), 32'd0);
    checkOutput("eor_wrap", 32'(wrapped), 32'd0);
    repeat (5) applyStimulus(1'b0, 1'b0, 7'd3, 3'd0);
    checkOutput("eor_final", 32'({done, busy, rom_addr, note_code}), 32'({1'b1, 1'b0, 7'd127, 8'h7F}));
    applyStimulus(1'b0, 1'b1, 7'd0, 3'd0);

    // Abort: stop and start arrive together in mid-PLAY, and stop must win.
    fillRom(8'h10, 8'h20, 8'hFF);
    applyStimulus(1'b1, 1'b0, 7'd7, 3'd1);
    repeat (5) applyStimulus(1'b0, 1'b0, 7'd7, 3'd1);
    applyStimulus(1'b1, 1'b1, 7'd7, 3'd1);
    checkOutput("abort_state", 32'(actualOut()), 32'(packOut(7'd0, 7'd7, 3'd1, 8'h00, 1'b0, 1'b0, 1'b0)));
    pulses = 0; busyHigh = 0;
    repeat (30) begin
      applyStimulus(1'b0, 1'b0, 7'd7, 3'd1);
      if (note_valid) pulses++;
      if (busy) busyHigh++;
    end
    checkOutput("abort_quiet", 32'(pulses + busyHigh), 32'd0);

    // Async reset in mid-PLAY clears the outputs between clock edges. The next run replays from address 0.
    applyStimulus(1'b1, 1'b0, 7'd9, 3'd2);
    repeat (6) applyStimulus(1'b0, 1'b0, 7'd9, 3'd2);
    #2 KEY0 = 1'b0;
    #1 checkOutput("reset_async", 32'(actualOut()), 32'd0);
    start = 1'b1;
    pulses = 0;
    repeat (3) begin
      @(negedge CLOCK_50);
      if (note_valid || busy) pulses++;
    end
    checkOutput("reset_hold_quiet", 32'(pulses), 32'd0);
    KEY0 = 1'b1;
    applyStimulus(1'b0, 1'b0, 7'd9, 3'd2);
    checkOutput("reset_release_idle", 32'(actualOut()), 32'd0);
    applyStimulus(1'b1, 1'b0, 7'd9, 3'd2);
    lat = 1;
    while (!note_valid && lat < 10) begin
      applyStimulus(1'b0, 1'b0, 7'd9, 3'd2);
      lat++;
    end
    checkOutput("replay_latency", 32'(lat), 32'd3);
    checkOutput("replay_note", 32'({rom_addr, note_code, seq_num, freq_num}),
                32'({7'd0, 8'h10, 7'd9, 3'd2}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
